// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared op-code encodings and execute-stage FSM states used by
//                alu_ctrl and alu_exec.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULT = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter
//  Description : Iterative unsigned shift-add multiplier datapath. One
//                multiplier bit is consumed per step; the product is complete
//                after WIDTH steps.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_mcand,
    input  logic [WIDTH-1:0]     i_mplier,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;
    logic [WIDTH:0]     w_sum;

    // Partial sum keeps its carry so the following right shift loses nothing
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + (r_mplier[0] ? {1'b0, r_mcand} : '0);

    // Load operands, or add-and-shift one multiplier bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_acc    <= '0;
            r_count  <= CW'(WIDTH);
        end else if (i_step) begin
            r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CW'(1);
        end
    end

    assign o_last    = (r_count == CW'(1));
    assign o_product = r_acc;

endmodule : mul_iter
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec
//  Description : Execute-stage ALU. Logic/arithmetic ops return a registered
//                result one cycle after issue; MULT runs iteratively and
//                stalls the upstream pipeline until HI/LO are written.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    input  logic [2:0]       i_operation,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_zero,
    output logic             o_overflow,
    output logic             o_out_valid,
    output logic             o_stall
);

    alu_state_e         r_state;
    alu_state_e         w_next_state;
    logic               w_load;
    logic               w_step;
    logic               w_issue_single;
    logic               w_mult_done;
    logic               w_last;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_ovf;

    mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_mcand   (i_a),
        .i_mplier  (i_b),
        .o_last    (w_last),
        .o_product (w_product)
    );

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control; flush forces IDLE and cancels any update
    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_step         = 1'b0;
        w_issue_single = 1'b0;
        w_mult_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_in_valid && !i_flush) begin
                    if (i_operation == OP_MULT) begin
                        w_load       = 1'b1;
                        w_next_state = ST_BUSY;
                    end else begin
                        w_issue_single = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_mult_done  = !i_flush;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (i_flush) begin
            w_next_state = ST_IDLE;
        end
    end

    // Single-cycle op result and signed overflow
    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (i_operation)
            OP_AND: w_alu_res = i_a & i_b;
            OP_OR:  w_alu_res = i_a | i_b;
            OP_NOR: w_alu_res = ~(i_a | i_b);
            OP_XOR: w_alu_res = i_a ^ i_b;
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1])
                         && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1])
                         && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: w_alu_res = '0;
        endcase
    end

    // Output registers: written on a single-cycle issue or on MULT completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_result    <= '0;
            o_hi        <= '0;
            o_zero      <= 1'b0;
            o_overflow  <= 1'b0;
            o_out_valid <= 1'b0;
        end else begin
            o_out_valid <= 1'b0;
            if (w_issue_single) begin
                o_result    <= w_alu_res;
                o_zero      <= (w_alu_res == '0);
                o_overflow  <= w_alu_ovf;
                o_out_valid <= 1'b1;
            end else if (w_mult_done) begin
                o_result    <= w_product[WIDTH-1:0];
                o_hi        <= w_product[2*WIDTH-1:WIDTH];
                o_zero      <= (w_product[WIDTH-1:0] == '0);
                o_overflow  <= 1'b0;
                o_out_valid <= 1'b1;
            end
        end
    end

    assign o_stall = (r_state != ST_IDLE);

endmodule : alu_exec
`default_nettype wire
